// File: rtl/mem_ls_resp_pkg.sv
// -----------------------------------------------------------------------------
// mem_ls_resp_pkg
// Shared definitions for the load/store-unit <-> memory request interface:
// data/address widths, rw_flag codes, len codes, responder FSM state type and
// the alignment helper used when MEM_ALIGN_CHECK_EN is defined.
// -----------------------------------------------------------------------------
package mem_ls_resp_pkg;

  localparam int dataWidth = 32;
  localparam int addrWidth = 32;

  // rw_flag encoding; 2'b11 is treated as "no request".
  localparam logic [1:0] RW_NONE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  // len encoding: byte count minus one, identical to the load/store unit.
  localparam logic [1:0] LEN_1B = 2'b00;
  localparam logic [1:0] LEN_2B = 2'b01;
  localparam logic [1:0] LEN_3B = 2'b10;
  localparam logic [1:0] LEN_4B = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_e;

  // Halfwords need addr[0]==0, words need addr[1:0]==0; bytes and 3-byte
  // accesses are never misaligned.
  function automatic logic is_misaligned(input logic [1:0] len_code,
                                         input logic [1:0] addr_lo);
    logic r;
    r = 1'b0;
    case (len_code)
      LEN_2B:         r = addr_lo[0];
      LEN_4B:         r = (addr_lo != 2'b00);
      LEN_1B, LEN_3B: r = 1'b0;
      default:        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_ls_resp.sv
// -----------------------------------------------------------------------------
// mem_ls_resp
// Responder for load/store requests. A one-cycle rw_flag pulse is accepted in
// IDLE, the access is run byte-serially on the 8-bit RAM port (little endian,
// byte k at addr+k) and completion is signalled with a one-cycle mem_done.
//
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned halfword /
// word requests (no RAM cycle, mem_err=1 with mem_done one cycle after accept).
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   rdy             global enable; low stalls everything, ram_wr forced 0
//   rw_flag         00 none, 01 read, 10 write, 11 none
//   addr, len       byte address of byte 0, byte count minus one
//   write_data      store data, byte k = bits [8k+7:8k]
//   read_data       load result, unfetched bytes are 0
//   mem_busy        high while an access is in READ/WRITE
//   mem_done        one-cycle completion pulse
//   mem_err         misalignment flag, valid with mem_done
//   ram_a/ram_wr/ram_dout  byte-wide RAM address, write strobe, write byte
//   ram_din         RAM read byte for the previous cycle's ram_a
// -----------------------------------------------------------------------------
module mem_ls_resp
  import mem_ls_resp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic [1:0]           rw_flag,
  input  logic [addrWidth-1:0] addr,
  input  logic [1:0]           len,
  input  logic [dataWidth-1:0] write_data,
  output logic [dataWidth-1:0] read_data,
  output logic                 mem_busy,
  output logic                 mem_done,
  output logic                 mem_err,
  output logic [addrWidth-1:0] ram_a,
  output logic                 ram_wr,
  output logic [7:0]           ram_dout,
  input  logic [7:0]           ram_din
);

  state_e                 r_state;
  logic [addrWidth-1:0]   r_addr;
  logic [1:0]             r_len;
  logic [dataWidth-1:0]   r_wdata;
  logic [dataWidth-1:0]   r_rdata;
  logic [1:0]             r_idx;     // write byte k / read issue pointer i
  logic [1:0]             r_cap;     // read capture pointer c
  logic                   r_cap_en;  // ram_din valid: first read address issued
  logic                   r_err;

  logic                   w_req;
  logic                   w_misaligned;

  assign w_req = (rw_flag == RW_READ) || (rw_flag == RW_WRITE);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misaligned = is_misaligned(len, addr[1:0]);
`else
  assign w_misaligned = 1'b0;
`endif

  // NOTE: all state below updates with non-blocking assignments so every
  // register sees the pre-edge values of the others, independent of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_len    <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_idx    <= '0;
      r_cap    <= '0;
      r_cap_en <= 1'b0;
      r_err    <= 1'b0;
    end else if (rdy) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr   <= addr;
            r_len    <= len;
            r_wdata  <= write_data;
            r_rdata  <= '0;
            r_idx    <= '0;
            r_cap    <= '0;
            r_cap_en <= 1'b0;
            r_err    <= w_misaligned;
            if (w_misaligned)            r_state <= S_DONE;
            else if (rw_flag == RW_READ) r_state <= S_READ;
            else                         r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (r_idx == r_len) r_state <= S_DONE;
          else                r_idx   <= r_idx + 2'd1;
        end
        S_READ: begin
          // Issue runs one byte ahead of capture because the RAM answers a
          // cycle late; it parks on the last byte once reached.
          if (r_idx != r_len) r_idx <= r_idx + 2'd1;
          r_cap_en <= 1'b1;
          if (r_cap_en) begin
            r_rdata[8*r_cap +: 8] <= ram_din;
            if (r_cap == r_len) r_state <= S_DONE;
            else                r_cap   <= r_cap + 2'd1;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every output is given a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    ram_a    = '0;
    ram_wr   = 1'b0;
    ram_dout = '0;
    unique case (r_state)
      S_WRITE: begin
        ram_a    = r_addr + addrWidth'(r_idx);
        ram_wr   = rdy;
        ram_dout = r_wdata[8*r_idx +: 8];
      end
      S_READ: begin
        // While stalled, re-present the capture address so ram_din still
        // carries the pending byte when rdy returns.
        ram_a = r_addr + addrWidth'(rdy ? r_idx : r_cap);
      end
      default: ;
    endcase
  end

  assign mem_busy  = (r_state == S_READ) || (r_state == S_WRITE);
  assign mem_done  = (r_state == S_DONE);
  assign mem_err   = (r_state == S_DONE) && r_err;
  assign read_data = r_rdata;

endmodule

// File: tb/tb_mem_ls_resp.sv
// -----------------------------------------------------------------------------
// tb_mem_ls_resp
// Directed scoreboard bench for mem_ls_resp with a byte-wide RAM model.
// Stimulus pushes the hand-computed response; a negedge monitor pops and
// compares read_data, mem_err, completion cycle and busy cycle count on
// every mem_done.
// -----------------------------------------------------------------------------
module tb_mem_ls_resp;
  import mem_ls_resp_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 rdy;
  logic [1:0]           rw_flag;
  logic [addrWidth-1:0] addr;
  logic [1:0]           len;
  logic [dataWidth-1:0] write_data;
  logic [dataWidth-1:0] read_data;
  logic                 mem_busy;
  logic                 mem_done;
  logic                 mem_err;
  logic [addrWidth-1:0] ram_a;
  logic                 ram_wr;
  logic [7:0]           ram_dout;
  logic [7:0]           ram_din = 8'h00;

  mem_ls_resp dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .rw_flag    (rw_flag),
    .addr       (addr),
    .len        (len),
    .write_data (write_data),
    .read_data  (read_data),
    .mem_busy   (mem_busy),
    .mem_done   (mem_done),
    .mem_err    (mem_err),
    .ram_a      (ram_a),
    .ram_wr     (ram_wr),
    .ram_dout   (ram_dout),
    .ram_din    (ram_din)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          done_cyc;
    int          busy;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          done_seen   = 0;
  int          start_done  = 0;
  int          busy_cnt    = 0;
  int          wr_cnt      = 0;
  int          wr0;
  logic [7:0]  mem [logic [31:0]];
  logic [7:0]  din_next;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Byte RAM: ram_din carries the byte at the previous cycle's ram_a.
  always @(posedge clk) begin
    din_next = mem_rd(ram_a);
    if (ram_wr) begin
      mem[ram_a] = ram_dout;
      wr_cnt++;
    end
    ram_din <= din_next;
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (mem_busy) busy_cnt++;
      if (mem_done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check({mon_e.name, "_rdata"}, 64'(read_data), 64'(mon_e.rdata));
          check({mon_e.name, "_err"}, 64'(mem_err), 64'(mon_e.err));
          check({mon_e.name, "_done_cycle"}, 64'(cyc), 64'(mon_e.done_cyc));
          check({mon_e.name, "_busy_cycles"}, 64'(busy_cnt), 64'(mon_e.busy));
        end
        busy_cnt = 0;
        done_seen++;
      end
    end
  end

  // Drive a one-cycle request in cycle 0; optionally expect a response lat
  // cycles later. Returns at the negedge of cycle 1.
  task automatic start(input logic [1:0] rw, input logic [31:0] a, input logic [1:0] l,
                       input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_err, input int lat, input string name,
                       input bit expect_done);
    @(negedge clk);
    rw_flag    = rw;
    addr       = a;
    len        = l;
    write_data = wd;
    start_done = done_seen;
    if (expect_done) sb_q.push_back('{exp_rd, exp_err, cyc + lat, lat - 1, name});
    @(negedge clk);
    rw_flag = RW_NONE;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_seen == start_done && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_seen == start_done) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic access(input logic [1:0] rw, input logic [31:0] a, input logic [1:0] l,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input int lat, input string name);
    start(rw, a, l, wd, exp_rd, exp_err, lat, name, 1'b1);
    wait_done(name);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst        = 1'b1;
    rdy        = 1'b1;
    rw_flag    = RW_NONE;
    addr       = '0;
    len        = LEN_1B;
    write_data = '0;
    mem[32'h0000_0202] = 8'h5A;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(mem_busy), 64'd0);
    check("rst_done", 64'(mem_done), 64'd0);
    check("rst_err", 64'(mem_err), 64'd0);
    check("rst_ram_wr", 64'(ram_wr), 64'd0);
    check("rst_ram_a", 64'(ram_a), 64'd0);
    check("rst_ram_dout", 64'(ram_dout), 64'd0);
    check("rst_read_data", 64'(read_data), 64'd0);
    rst = 1'b0;

    // SW 0xDEADBEEF -> 0x100: writes cycles 1..4, done cycle 5.
    access(RW_WRITE, 32'h100, LEN_4B, 32'hDEADBEEF, 32'h0, 1'b0, 5, "sw");
    check("sw_b0", 64'(mem_rd(32'h100)), 64'hEF);
    check("sw_b1", 64'(mem_rd(32'h101)), 64'hBE);
    check("sw_b2", 64'(mem_rd(32'h102)), 64'hAD);
    check("sw_b3", 64'(mem_rd(32'h103)), 64'hDE);

    // LW / LB / 3-byte load.
    access(RW_READ, 32'h100, LEN_4B, 32'h0, 32'hDEADBEEF, 1'b0, 6, "lw");
    access(RW_READ, 32'h103, LEN_1B, 32'h0, 32'h000000DE, 1'b0, 3, "lb");
    access(RW_READ, 32'h100, LEN_3B, 32'h0, 32'h00ADBEEF, 1'b0, 5, "l3");

    // SH 0x1234 -> 0x200; 0x202 keeps its preload.
    access(RW_WRITE, 32'h200, LEN_2B, 32'hFFFF1234, 32'h0, 1'b0, 3, "sh");
    check("sh_b0", 64'(mem_rd(32'h200)), 64'h34);
    check("sh_b1", 64'(mem_rd(32'h201)), 64'h12);
    check("sh_b2_untouched", 64'(mem_rd(32'h202)), 64'h5A);

    // LW with rdy low in cycles 2-3: done in cycle 8, no writes.
    wr0 = wr_cnt;
    start(RW_READ, 32'h100, LEN_4B, 32'h0, 32'hDEADBEEF, 1'b0, 8, "lw_stall", 1'b1);
    @(negedge clk);
    rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rdy = 1'b1;
    wait_done("lw_stall");
    check("lw_stall_no_wr", 64'(wr_cnt), 64'(wr0));

    // Wrapping halfword store, with a write request during WRITE ignored.
    start(RW_WRITE, 32'hFFFF_FFFF, LEN_2B, 32'h0000A55A, 32'h0, 1'b0, 3, "sh_wrap", 1'b1);
    rw_flag    = RW_WRITE;
    addr       = 32'h400;
    len        = LEN_4B;
    write_data = 32'h11223344;
    @(negedge clk);
    rw_flag = RW_NONE;
    wait_done("sh_wrap");
    check("wrap_b0", 64'(mem_rd(32'hFFFF_FFFF)), 64'h5A);
    check("wrap_b1", 64'(mem_rd(32'h0)), 64'hA5);
    check("ignored_req", 64'(mem_rd(32'h400)), 64'h00);
    access(RW_READ, 32'hFFFF_FFFF, LEN_2B, 32'h0, 32'h0000A55A, 1'b0, 4, "lh_wrap");

`ifdef MEM_ALIGN_CHECK_EN
    wr0 = wr_cnt;
    access(RW_READ, 32'h102, LEN_4B, 32'h0, 32'h0, 1'b1, 1, "lw_misal");
    access(RW_WRITE, 32'h101, LEN_2B, 32'hFFFFFFFF, 32'h0, 1'b1, 1, "sh_misal");
    check("misal_no_wr", 64'(wr_cnt), 64'(wr0));
    check("misal_mem_kept", 64'(mem_rd(32'h101)), 64'hBE);
    access(RW_READ, 32'h102, LEN_2B, 32'h0, 32'h0000DEAD, 1'b0, 4, "lh_aligned");
`else
    access(RW_READ, 32'h101, LEN_2B, 32'h0, 32'h0000ADBE, 1'b0, 4, "lh_odd");
    access(RW_READ, 32'h102, LEN_4B, 32'h0, 32'h0000DEAD, 1'b0, 6, "lw_odd");
`endif

    // Reset asserted in cycle 2 of an SW: abort, no done, 0x302+ untouched.
    start(RW_WRITE, 32'h300, LEN_4B, 32'hCAFEF00D, 32'h0, 1'b0, 0, "sw_abort", 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(mem_busy), 64'd0);
    check("abort_done", 64'(mem_done), 64'd0);
    repeat (6) @(negedge clk);
    #1;
    check("abort_no_done", 64'(done_seen), 64'(start_done));
    check("abort_b0", 64'(mem_rd(32'h300)), 64'h0D);
    check("abort_b2", 64'(mem_rd(32'h302)), 64'h00);
    check("abort_b3", 64'(mem_rd(32'h303)), 64'h00);
    access(RW_READ, 32'h300, LEN_1B, 32'h0, 32'h0000000D, 1'b0, 3, "lb_after_rst");

    // rw_flag = 11 is no request.
    start(2'b11, 32'h500, LEN_4B, 32'h0, 32'h0, 1'b0, 0, "rw11", 1'b0);
    check("rw11_busy", 64'(mem_busy), 64'd0);
    repeat (4) @(negedge clk);
    #1;
    check("rw11_no_done", 64'(done_seen), 64'(start_done));

    repeat (2) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_ls_resp.md
# mem_ls_resp

Responder end of the load/store-unit ↔ memory request interface. It accepts one-cycle request pulses (`rw_flag`, `addr`, `len`, `write_data`), runs the access as byte-serial cycles on the 8-bit unified RAM port, and returns `mem_done` with little-endian assembled `read_data`. It sits between the load/store execute unit and the external byte-wide RAM.

## Interface
- `dataWidth`, 32, request data width (shared define)
- `addrWidth`, 32, address width (shared define)
- `clk` in 1, system clock
- `rst` in 1, synchronous active-high reset
- `rdy` in 1, global enable; low = stall
- `rw_flag` in 2, 00 none, 01 read, 10 write; 11 treated as none
- `addr` in `addrWidth`, byte address of byte 0
- `len` in 2, byte count minus 1 (00 = 1, 01 = 2, 10 = 3, 11 = 4)
- `write_data` in `dataWidth`, store data; byte k = bits [8k+7:8k]
- `read_data` out `dataWidth`, load result; bytes not fetched are 0
- `mem_busy` out 1, high from the cycle after accept until `mem_done`
- `mem_done` out 1, one-cycle completion pulse
- `mem_err` out 1, misalignment flag, valid with `mem_done`
- `ram_a` out `addrWidth`, RAM byte address
- `ram_wr` out 1, RAM write strobe
- `ram_dout` out 8, RAM write byte
- `ram_din` in 8, RAM read byte; returns the byte at the previous cycle's `ram_a`

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: when `rw_flag` is 01 or 10, latch `addr`, `len`, `write_data` and op; clear `read_data`; issue counter ← 0; go to READ or WRITE. Requests arriving in any other state are ignored.
- WRITE: each cycle, drive `ram_wr`=1, `ram_a`=addr+k, `ram_dout`=byte k, then increment k. After byte `len`, go to DONE.
- READ: the issue pointer i drives `ram_a`=addr+i with `ram_wr`=0. The capture pointer c stores `ram_din` into byte c on every cycle after the first issue. Leave READ when c = `len` is captured. The issue pointer stops at `len`.
- DONE: `mem_done`=1 and `mem_busy`=0 for one cycle, then return to IDLE. `read_data` holds until the next accept.
- Address arithmetic is modulo 2^`addrWidth`; 0xFFFFFFFF+1 wraps to 0.
- Stall (`rdy`=0): all registers hold and `ram_wr` is forced to 0. In READ, `ram_a` is driven combinationally with addr+c (the capture address), so on resume `ram_din` holds the correct pending byte. With `rdy`=1, `ram_a`=addr+i.
- Reset: state IDLE. `mem_busy`, `mem_done`, `mem_err`, `ram_wr` = 0. `ram_a`, `ram_dout`, `read_data` = 0.
- A reset mid-access aborts the access with no done pulse; a partially written word stays partially written.

## Timing
- Accept at edge E0 (request visible in cycle 0).
- Write of n bytes: RAM writes in cycles 1..n; `mem_done` in cycle n+1.
- Read of n bytes: addresses in cycles 1..n, captures in cycles 2..n+1, `mem_done` in cycle n+2 with `read_data` valid in the same cycle.
- Earliest next accept: the cycle after DONE. The requester's one-cycle `rw_flag` pulse after it sees `mem_done` meets this.
- Each stalled cycle adds exactly one cycle of latency.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: a request is misaligned when `len`=01 with addr[0]≠0, or when `len`=11 with addr[1:0]≠0. A misaligned request performs no RAM cycle and goes straight to DONE (done in cycle 1) with `mem_err`=1 and `read_data`=0.
- Undefined: `mem_err` is tied 0 and all accesses proceed.

## Structure
- The shared defines header holds `dataWidth`, `addrWidth`, the rw codes (`RW_NONE`/`RW_READ`/`RW_WRITE`) and the len codes. `len` codes match the load/store unit's encoding exactly.
- Single module; no sub-module. Byte lane select and assembly are inline.

## Test plan
- SW 0xDEADBEEF to 0x100 → RAM writes 0x100=EF, 0x101=BE, 0x102=AD, 0x103=DE in cycles 1–4; `mem_done` in cycle 5.
- LW from 0x100 after the store above → `read_data`=0xDEADBEEF at cycle 6; `mem_busy` high cycles 1–5.
- LB from 0x103 → `read_data`=0x000000DE in cycle 3. SH 0x1234 to 0x200 → 0x200=34, 0x201=12, and 0x202 is untouched.
- LW from 0x100 with `rdy` low in cycles 2–3 → `read_data` still 0xDEADBEEF; done delayed to cycle 8; no `ram_wr` pulses.
- Write to 0xFFFFFFFF with `len`=01 → bytes land at 0xFFFFFFFF and 0x0. `rw_flag`=10 asserted during WRITE is ignored.
- With `MEM_ALIGN_CHECK_EN`: LW at 0x102 → done cycle 1, `mem_err`=1, no RAM access. Reset asserted in cycle 2 of an SW → state IDLE, no `mem_done`.
